// File: rtl/led_strip_pkg.sv
// Shared constants for the LED strip transmitter: colour-order encodings,
// 74.25 MHz default timing, FSM state type and the brightness scaling helper.
package led_strip_pkg;

    localparam int ORDER_GRB = 0;
    localparam int ORDER_RGB = 1;

    localparam int DEF_N_LEDS   = 60;
    localparam int DEF_TBIT_CYC = 93;
    localparam int DEF_T0H_CYC  = 26;
    localparam int DEF_T1H_CYC  = 52;
    localparam int DEF_TRST_CYC = 22275;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // (c * (b + 1)) >> 8: b = 255 passes c through, b = 0 maps 255 to 0
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

endpackage

// File: rtl/led_rz_bit.sv
// Return-to-zero bit timer: a down-counter spanning one bit period, with the
// high/low split chosen by the current bit value and a strobe on the last clock.
module led_rz_bit #(
    parameter int TBIT_CYC = 93,
    parameter int T0H_CYC  = 26,
    parameter int T1H_CYC  = 52
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    input  logic bit_val,
    output logic dout,
    output logic bit_done
);

    localparam int CW = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] T0_TH   = CW'(TBIT_CYC - 1 - T0H_CYC);
    localparam logic [CW-1:0] T1_TH   = CW'(TBIT_CYC - 1 - T1H_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_MAX;
        end else if (run) begin
            cnt <= (cnt == '0) ? CNT_MAX : cnt - 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // high for the first T0H/T1H clocks of the period, counted down from CNT_MAX
    assign dout     = run && (cnt > (bit_val ? T1_TH : T0_TH));
    assign bit_done = run && (cnt == '0);

endmodule

// File: rtl/led_strip_tx.sv
// Frame-level WS281x-style transmitter: latches the framebuffer on start, shifts
// each LED word MSB first through led_rz_bit, then holds the latch gap.
// Optional global brightness scaling is enabled by defining LED_STRIP_BRIGHTNESS_EN.
//
// state | meaning
// IDLE  | waiting for start; dout low
// SEND  | serialising LED words back to back
// GAP   | dout low for TRST_CYC clocks; done on the last one
module led_strip_tx
    import led_strip_pkg::*;
#(
    parameter int N_LEDS   = DEF_N_LEDS,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TRST_CYC = DEF_TRST_CYC,
    parameter int ORDER    = ORDER_GRB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [24*N_LEDS-1:0]  framebuffer,
`ifdef LED_STRIP_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  dout
);

    localparam int FBW = 24 * N_LEDS;
    localparam int IW  = (FBW > 1) ? $clog2(FBW) : 1;
    localparam int GW  = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;
    localparam logic [7:0]    LAST_LED = 8'(N_LEDS - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TRST_CYC - 1);

    state_t state, state_n;

    logic [FBW-1:0] fb_q;
    logic [23:0]    shift;
    logic [4:0]     bit_cnt;
    logic [7:0]     led_idx;
    logic [GW-1:0]  gap_cnt;

    logic           accept, bit_done, last_bit;
    logic [7:0]     nidx;
    logic [IW-1:0]  nbase;
    logic [23:0]    next_raw, first_rgb, next_rgb;

    function automatic logic [23:0] reorder(input logic [23:0] rgb);
        return (ORDER == ORDER_RGB) ? rgb : {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    assign accept   = (state == IDLE) && start;
    assign last_bit = bit_done && (bit_cnt == 5'd0) && (led_idx == LAST_LED);

    // next word is fetched from the latched copy while the current one shifts
    assign nidx     = (led_idx == LAST_LED) ? 8'd0 : led_idx + 8'd1;
    assign nbase    = IW'(32'(nidx) * 32'd24);
    assign next_raw = fb_q[nbase +: 24];

`ifdef LED_STRIP_BRIGHTNESS_EN
    logic [7:0] br_q;

    function automatic logic [23:0] scale_rgb(input logic [23:0] rgb, input logic [7:0] b);
        return {scale_byte(rgb[23:16], b), scale_byte(rgb[15:8], b), scale_byte(rgb[7:0], b)};
    endfunction

    assign first_rgb = scale_rgb(framebuffer[23:0], brightness);
    assign next_rgb  = scale_rgb(next_raw, br_q);

    always_ff @(posedge clk) begin
        if (rst)         br_q <= '0;
        else if (accept) br_q <= brightness;
    end
`else
    assign first_rgb = framebuffer[23:0];
    assign next_rgb  = next_raw;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)              state_n = SEND;
            SEND:    if (last_bit)           state_n = GAP;
            GAP:     if (gap_cnt == '0)      state_n = IDLE;
            default:                         state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fb_q    <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            led_idx <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                fb_q    <= framebuffer;
                shift   <= reorder(first_rgb);
                bit_cnt <= 5'd23;
                led_idx <= 8'd0;
            end else if (bit_done) begin
                if (bit_cnt == 5'd0) begin
                    bit_cnt <= 5'd23;
                    shift   <= last_bit ? 24'd0 : reorder(next_rgb);
                    led_idx <= nidx;
                end else begin
                    bit_cnt <= bit_cnt - 5'd1;
                    shift   <= {shift[22:0], 1'b0};
                end
            end
            if (last_bit)
                gap_cnt <= GAP_MAX;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    led_rz_bit #(
        .TBIT_CYC (TBIT_CYC),
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC)
    ) u_rz_bit (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .run      (state == SEND),
        .bit_val  (shift[23]),
        .dout     (dout),
        .bit_done (bit_done)
    );

    assign busy = (state != IDLE);
    assign done = (state == GAP) && (gap_cnt == '0);

endmodule

// File: tb/tb_led_strip_tx.sv
// Directed bench for led_strip_tx: two instances (GRB and RGB order) driven in
// parallel, waveforms decoded back into bits and compared with hand-built frames.
module tb_led_strip_tx;

    localparam int NL   = 2;
    localparam int TB   = 10;
    localparam int MAXC = 600;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [24*NL-1:0] framebuffer;
`ifdef LED_STRIP_BRIGHTNESS_EN
    logic [7:0]      brightness;
`endif
    logic busy0, done0, dout0, busy1, done1, dout1;

    int total = 0;
    int bad   = 0;

    logic wave0 [MAXC+1];
    logic wave1 [MAXC+1];
    int busy_n0, busy_n1, done_n, done_at, end_at;

    always #5 clk = ~clk;

    led_strip_tx #(.N_LEDS(NL), .TBIT_CYC(TB), .T0H_CYC(3), .T1H_CYC(6), .TRST_CYC(20), .ORDER(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .framebuffer(framebuffer),
`ifdef LED_STRIP_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy0), .done(done0), .dout(dout0));

    led_strip_tx #(.N_LEDS(NL), .TBIT_CYC(TB), .T0H_CYC(3), .T1H_CYC(6), .TRST_CYC(20), .ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .framebuffer(framebuffer),
`ifdef LED_STRIP_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy1), .done(done1), .dout(dout1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // start is driven in cycle 0; extra start pulses land in cycles p1..p3
    task automatic run_frame(input logic [47:0] fbv, input int p1, input int p2, input int p3,
                             input bit scramble);
        logic [63:0] rnd;
        framebuffer = fbv;
        start = 1'b1;
        for (int i = 0; i <= MAXC; i++) begin wave0[i] = 1'b0; wave1[i] = 1'b0; end
        busy_n0 = 0; busy_n1 = 0; done_n = 0; done_at = -1; end_at = -1;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            start = (c == p1) || (c == p2) || (c == p3);
            if (scramble) begin
                rnd = {$urandom, $urandom};
                framebuffer = rnd[47:0];
            end
            wave0[c] = dout0;
            wave1[c] = dout1;
            if (busy0) busy_n0++;
            if (busy1) busy_n1++;
            if (done0) begin done_n++; done_at = c; end
            if (!busy0 && !busy1) begin end_at = c; break; end
        end
        framebuffer = fbv;
        check("frame_end_cycle", 64'(end_at), 64'd501);
    endtask

    task automatic decode(input bit which, output logic [47:0] bits, output bit shape_ok);
        int h;
        logic v;
        shape_ok = 1'b1;
        bits = '0;
        for (int k = 0; k < 48; k++) begin
            h = 0;
            for (int j = 0; j < TB; j++) begin
                v = which ? wave1[1 + TB*k + j] : wave0[1 + TB*k + j];
                if (v && j == h) h++;
                else if (v) shape_ok = 1'b0;
            end
            if (h == 6)      bits[47-k] = 1'b1;
            else if (h != 3) shape_ok = 1'b0;
        end
        for (int c = 481; c <= 501; c++)
            if (wave0[c] || wave1[c]) shape_ok = 1'b0;
    endtask

    task automatic check_frame(input logic [47:0] e0, input logic [47:0] e1);
        logic [47:0] b0, b1;
        bit ok0, ok1;
        decode(1'b0, b0, ok0);
        decode(1'b1, b1, ok1);
        check("grb_bits", {15'd0, ok0, b0}, {15'd0, 1'b1, e0});
        check("rgb_bits", {15'd0, ok1, b1}, {15'd0, 1'b1, e1});
        check("busy_len", {32'(busy_n0), 32'(busy_n1)}, {32'd500, 32'd500});
        check("done_pulse", {32'(done_n), 32'(done_at)}, {32'd1, 32'd500});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 1000) begin @(negedge clk); n++; end
        check("idle_timeout", 64'(busy0 || busy1), 64'd0);
    endtask

    typedef struct {
        logic [47:0] fb;
        logic [47:0] e0;
        logic [47:0] e1;
    } vec_t;

    vec_t vecs [4];
    bit   done_seen;

    initial begin
        // framebuffer = {LED1, LED0}; expected = wire bit stream, first bit in bit 47
        vecs[0] = '{48'h000000_FF0000, 48'h00FF00_000000, 48'hFF0000_000000};
        vecs[1] = '{48'hA5C3E1_123456, 48'h341256_C3A5E1, 48'h123456_A5C3E1};
        vecs[2] = '{48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF};
        vecs[3] = '{48'h800000_000001, 48'h000001_008000, 48'h000001_800000};

        rst = 1'b1; start = 1'b0; framebuffer = '0;
`ifdef LED_STRIP_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", {61'd0, busy0 | busy1, done0 | done1, dout0 | dout1}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].fb, -1, -1, -1, 1'b0);
            check_frame(vecs[i].e0, vecs[i].e1);
        end

        // starts while busy (incl. the done cycle) are ignored; next cycle is accepted
        run_frame(vecs[0].fb, 5, 300, 500, 1'b0);
        check_frame(vecs[0].e0, vecs[0].e1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_after_done", {62'd0, busy0, dout0}, 64'd3);
        wait_idle();

        // reset mid-SEND at cycle 250, then a fresh frame from cycle 260
        framebuffer = vecs[1].fb;
        start = 1'b1;
        done_seen = 1'b0;
        for (int c = 1; c <= 259; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (c == 250);
            if (done0 || done1) done_seen = 1'b1;
            if (c == 251)
                check("rst_mid_send", {61'd0, busy0 | busy1, done0 | done1, dout0 | dout1}, 64'd0);
        end
        check("no_done_after_rst", 64'(done_seen), 64'd0);
        run_frame(vecs[0].fb, -1, -1, -1, 1'b0);
        check_frame(vecs[0].e0, vecs[0].e1);

        // framebuffer churns every cycle; the frame latched at start must go out
        run_frame(vecs[1].fb, -1, -1, -1, 1'b1);
        check_frame(vecs[1].e0, vecs[1].e1);

`ifdef LED_STRIP_BRIGHTNESS_EN
        brightness = 8'h7F;
        run_frame(48'h000000_FF8040, -1, -1, -1, 1'b0);
        check_frame(48'h407F20_000000, 48'h7F4020_000000);
        brightness = 8'h00;
        run_frame(48'hFFFFFF_FFFFFF, -1, -1, -1, 1'b0);
        check_frame(48'h0, 48'h0);
        brightness = 8'hFF;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
